peri_ram_stream_rd: RTL and testbench

//  Read-side engine for the 256x8 peripheral dual-port RAM (Ram8a8d2), used as a circular byte buffer.
//  The peripheral writer fills the RAM and publishes its write pointer. This block drives the RAM read port.
//  It absorbs the 1-cycle RAM read latency and streams bytes out on a valid/ready interface.
//  It returns its read pointer to the writer for free-space accounting.

---
 rtl/peri_ram_pkg.sv | 19 +
 rtl/peri_skid2.sv | 87 ++++++++
 rtl/peri_ram_stream_rd.sv | 112 +++++++++++
 tb/tb_peri_ram_stream_rd.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/peri_ram_pkg.sv
// Shared definitions for the peripheral RAM stream blocks.
// Provides the pointer and byte widths, their typedefs, and the
// pointer-difference helper used for level accounting.
package peri_ram_pkg;

    localparam int CAddrW = 8;
    localparam int CDataW = 8;

    typedef logic [CAddrW-1:0] TPtr;
    typedef logic [CDataW-1:0] TByte;

    // Unread distance from rd up to wr on the circular buffer, zero-extended.
    function automatic logic [CAddrW:0] PtrDiff(input TPtr wr, input TPtr rd);
        TPtr w_diff;
        w_diff = wr - rd;
        return {1'b0, w_diff};
    endfunction

endpackage

// File: rtl/peri_skid2.sv
// Two-entry push/pop FIFO with occupancy count, clock enable and sync clear.
// The head entry is the registered output; it keeps its last value when the
// FIFO drains so downstream data does not glitch.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_en               clock enable; 0 freezes all state
//   i_clr              synchronous clear of the count (qualified by i_en)
//   i_push/i_push_data write one byte
//   i_pop              consume the head (only legal when o_valid)
//   o_data, o_valid    head byte and non-empty flag
//   o_cnt              occupancy 0..2
module peri_skid2
    import peri_ram_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_clr,
    input  logic       i_push,
    input  TByte       i_push_data,
    input  logic       i_pop,
    output TByte       o_data,
    output logic       o_valid,
    output logic [1:0] o_cnt
);

    TByte       r_head;
    TByte       r_tail;
    logic [1:0] r_cnt;
    logic       r_valid;

    // Occupancy, storage and valid flag update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            if (i_clr) begin
                r_cnt   <= 2'd0;
                r_valid <= 1'b0;
            end else begin
                case ({i_push, i_pop})
                    2'b10: begin
                        if (r_cnt == 2'd0) begin
                            r_head <= i_push_data;
                        end else begin
                            r_tail <= i_push_data;
                        end
                        r_cnt   <= r_cnt + 2'd1;
                        r_valid <= 1'b1;
                    end
                    2'b01: begin
                        // With one entry the head simply holds its stale value.
                        if (r_cnt == 2'd2) begin
                            r_head <= r_tail;
                        end else begin
                            r_head <= r_head;
                        end
                        r_cnt   <= r_cnt - 2'd1;
                        r_valid <= (r_cnt == 2'd2);
                    end
                    2'b11: begin
                        if (r_cnt == 2'd2) begin
                            r_head <= r_tail;
                            r_tail <= i_push_data;
                        end else begin
                            r_head <= i_push_data;
                        end
                        r_valid <= 1'b1;
                    end
                    default: begin
                        r_cnt <= r_cnt;
                    end
                endcase
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_data  = r_head;
    assign o_valid = r_valid;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/peri_ram_stream_rd.sv
// Read-side engine for the 256x8 peripheral dual-port RAM used as a circular
// byte buffer. Issues reads below the writer's pointer, absorbs the one-cycle
// RAM latency in a 2-entry skid FIFO and streams bytes on valid/ready.
// Ports:
//   AClkH, AResetB, AClkHEn  clock, async active-low reset, clock enable
//   AWrPtr                   writer's next-write address
//   AFlush                   drop unread data, pointers jump to AWrPtr
//   ARamAddr / ARamMiso      RAM read address / read data (1-cycle latency)
//   AData, AValid, AReady    output byte stream
//   ARdPtr                   next address to be consumed
//   ALevel                   unread bytes (AWrPtr - ARdPtr)
module peri_ram_stream_rd
    import peri_ram_pkg::*;
(
    input  logic              AClkH,
    input  logic              AResetB,
    input  logic              AClkHEn,
    input  logic [CAddrW-1:0] AWrPtr,
    input  logic              AFlush,
    output logic [CAddrW-1:0] ARamAddr,
    input  logic [CDataW-1:0] ARamMiso,
    output logic [CDataW-1:0] AData,
    output logic              AValid,
    input  logic              AReady,
    output logic [CAddrW-1:0] ARdPtr,
    output logic [CAddrW:0]   ALevel
);

    TPtr        r_iss_ptr;
    TPtr        r_rd_ptr;
    logic       r_pend;
    logic [1:0] w_cnt;
    logic       w_valid;
    logic       w_pop;
    logic       w_room;
    logic       w_issue;
    TPtr        w_ram_addr;

    assign w_pop = w_valid & AReady & AClkHEn;

    // Issue decision. Qualified by enable and reset so that, when idle, the RAM
    // keeps reading the last-issued address and its output stays valid.
    always_comb begin
        w_room  = 1'b0;
        w_issue = 1'b0;
        w_room  = (({1'b0, w_cnt} + {2'b00, r_pend} - {2'b00, w_pop}) < 3'd2);
        if (AResetB && AClkHEn && !AFlush && (r_iss_ptr != AWrPtr) && w_room) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
    end

    // RAM address: the new pointer when issuing, otherwise the previous one.
    always_comb begin
        w_ram_addr = r_iss_ptr;
        if (w_issue) begin
            w_ram_addr = r_iss_ptr;
        end else begin
            w_ram_addr = r_iss_ptr - TPtr'(1'b1);
        end
    end

    // Issue/read pointers and the in-flight flag.
    always_ff @(posedge AClkH or negedge AResetB) begin
        if (!AResetB) begin
            r_iss_ptr <= '0;
            r_rd_ptr  <= '0;
            r_pend    <= 1'b0;
        end else if (AClkHEn) begin
            if (AFlush) begin
                // Flush wins over a simultaneous pop; in-flight byte is dropped.
                r_iss_ptr <= AWrPtr;
                r_rd_ptr  <= AWrPtr;
                r_pend    <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_iss_ptr <= r_iss_ptr + TPtr'(1'b1);
                end else begin
                    r_iss_ptr <= r_iss_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + TPtr'(1'b1);
                end else begin
                    r_rd_ptr <= r_rd_ptr;
                end
                r_pend <= w_issue;
            end
        end else begin
            r_pend <= r_pend;
        end
    end

    peri_skid2 u_skid (
        .i_clk       (AClkH),
        .i_rst_n     (AResetB),
        .i_en        (AClkHEn),
        .i_clr       (AFlush),
        .i_push      (r_pend),
        .i_push_data (ARamMiso),
        .i_pop       (w_pop),
        .o_data      (AData),
        .o_valid     (w_valid),
        .o_cnt       (w_cnt)
    );

    assign AValid   = w_valid;
    assign ARamAddr = w_ram_addr;
    assign ARdPtr   = r_rd_ptr;
    assign ALevel   = PtrDiff(AWrPtr, r_rd_ptr);

endmodule

// File: tb/tb_peri_ram_stream_rd.sv
module tb_peri_ram_stream_rd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] wr_ptr;
    logic       flush;
    logic [7:0] ram_addr;
    logic [7:0] ram_q;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [7:0] rd_ptr;
    logic [8:0] level;

    logic [7:0] mem [256];
    logic [7:0] exp_q [$];
    logic [7:0] wr_m;
    logic [7:0] rd_m;
    int         n_cmp = 0;
    int         n_err = 0;
    int         rx_cnt = 0;

    typedef struct {
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [7:0] exp_rd;
        logic [7:0] exp_addr;
        logic [8:0] exp_level;
    } vec_t;
    vec_t burst_tbl [6];

    always #5 clk = ~clk;

    // RAM read port: registered read, clocked every cycle.
    always @(posedge clk) ram_q <= mem[ram_addr];

    peri_ram_stream_rd dut (
        .AClkH    (clk),
        .AResetB  (rst_n),
        .AClkHEn  (en),
        .AWrPtr   (wr_ptr),
        .AFlush   (flush),
        .ARamAddr (ram_addr),
        .ARamMiso (ram_q),
        .AData    (data),
        .AValid   (valid),
        .AReady   (ready),
        .ARdPtr   (rd_ptr),
        .ALevel   (level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Writer publishes a new pointer; every newly covered byte joins the expected stream.
    task automatic set_wr(input logic [7:0] new_wr);
        logic [7:0] a;
        a = wr_m;
        while (a != new_wr) begin
            exp_q.push_back(mem[a]);
            a = a + 8'd1;
        end
        wr_m   = new_wr;
        wr_ptr = new_wr;
    endtask

    task automatic write_bytes(input int n);
        logic [7:0] a;
        a = wr_m;
        for (int i = 0; i < n; i++) begin
            mem[a] = 8'($urandom_range(0, 255));
            a = a + 8'd1;
        end
        set_wr(a);
    endtask

    // One clock: score a transfer before the edge, check pointers after it.
    task automatic tick();
        logic       xfer;
        logic       hv;
        logic [7:0] hd;
        logic [7:0] hr;
        logic       e;
        logic       f;
        #2;
        xfer = rst_n && en && !flush && valid && ready;
        if (xfer) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_xfer: got byte %0h expected none at %0t", data, $time);
            end else begin
                check("stream_byte", {24'd0, data}, {24'd0, exp_q[0]});
                void'(exp_q.pop_front());
                rd_m = rd_m + 8'd1;
                rx_cnt++;
            end
        end
        hv = valid; hd = data; hr = rd_ptr; e = en; f = flush;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (!e) begin
                check("hold_valid", {31'd0, valid}, {31'd0, hv});
                check("hold_data", {24'd0, data}, {24'd0, hd});
                check("hold_rdptr", {24'd0, rd_ptr}, {24'd0, hr});
            end else if (f) begin
                exp_q.delete();
                rd_m = wr_m;
            end
            check("rdptr", {24'd0, rd_ptr}, {24'd0, rd_m});
            check("level", {23'd0, level}, {24'd0, 8'(wr_m - rd_m)});
        end
    endtask

    task automatic drain(input int maxc);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || valid) && c < maxc) begin
            tick();
            c++;
        end
        n_cmp++;
        if (c >= maxc) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d bytes left expected 0", exp_q.size());
        end
        check("drained_valid", {31'd0, valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] snap;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0; en = 1'b1; wr_ptr = 8'h00; flush = 1'b0; ready = 1'b0;
        wr_m = 8'h00; rd_m = 8'h00;

        burst_tbl[0] = '{1'b1, 1'b0, 8'h00, 8'd0, 8'd1, 9'd4};
        burst_tbl[1] = '{1'b1, 1'b1, 8'h11, 8'd0, 8'd2, 9'd4};
        burst_tbl[2] = '{1'b1, 1'b1, 8'h22, 8'd1, 8'd3, 9'd3};
        burst_tbl[3] = '{1'b1, 1'b1, 8'h33, 8'd2, 8'd3, 9'd2};
        burst_tbl[4] = '{1'b1, 1'b1, 8'h44, 8'd3, 8'd3, 9'd1};
        burst_tbl[5] = '{1'b1, 1'b0, 8'h44, 8'd4, 8'd3, 9'd0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_rdptr", {24'd0, rd_ptr}, 32'd0);
        check("rst_addr", {24'd0, ram_addr}, 32'hFF);
        check("rst_level", {23'd0, level}, 32'd0);
        rst_n = 1'b1;

        // Burst of four known bytes, table-driven cycle by cycle.
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        set_wr(8'd4);
        for (int i = 0; i < 6; i++) begin
            ready = burst_tbl[i].ready;
            tick();
            check("burst_valid", {31'd0, valid}, {31'd0, burst_tbl[i].exp_valid});
            check("burst_data", {24'd0, data}, {24'd0, burst_tbl[i].exp_data});
            check("burst_rdptr", {24'd0, rd_ptr}, {24'd0, burst_tbl[i].exp_rd});
            check("burst_addr", {24'd0, ram_addr}, {24'd0, burst_tbl[i].exp_addr});
            check("burst_level", {23'd0, level}, {23'd0, burst_tbl[i].exp_level});
        end

        // Backpressure: six bytes queued, sink stalled for five cycles.
        ready = 1'b0;
        write_bytes(6);
        snap = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) snap = data;
        end
        check("bp_valid", {31'd0, valid}, 32'd1);
        check("bp_data", {24'd0, data}, {24'd0, exp_q[0]});
        check("bp_stable", {24'd0, data}, {24'd0, snap});
        check("bp_rdptr", {24'd0, rd_ptr}, 32'd4);
        check("bp_addr", {24'd0, ram_addr}, 32'd5);
        ready = 1'b1;
        drain(40);

        // Asynchronous reset in the middle of a stream.
        write_bytes(8);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_valid", {31'd0, valid}, 32'd0);
        check("amid_rdptr", {24'd0, rd_ptr}, 32'd0);
        check("amid_level", {23'd0, level}, {24'd0, wr_m});
        check("amid_addr", {24'd0, ram_addr}, 32'hFF);
        check("amid_data", {24'd0, data}, 32'd0);
        wr_m = 8'h00; wr_ptr = 8'h00; rd_m = 8'h00;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random clock enable, backpressure and writer bursts over 20 bytes.
        rx_cnt = 0;
        begin
            int sent;
            int cyc;
            sent = 0;
            cyc = 0;
            while ((sent < 20 || exp_q.size() != 0) && cyc < 2000) begin
                if (sent < 20 && ($urandom % 3) == 0) begin
                    int k;
                    k = $urandom_range(1, 3);
                    if (k > 20 - sent) k = 20 - sent;
                    write_bytes(k);
                    sent += k;
                end
                en    = 1'($urandom % 2);
                ready = ($urandom % 4) != 0;
                tick();
                cyc++;
            end
        end
        en = 1'b1;
        ready = 1'b1;
        drain(40);
        check("ce_count", rx_cnt, 32'd20);

        // Wrap across 0xFF -> 0x00 after flushing the pointers to 0xFE.
        wr_m = 8'hFE; wr_ptr = 8'hFE; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("wrap_start", {24'd0, rd_ptr}, 32'hFE);
        mem[8'hFE] = 8'hA0; mem[8'hFF] = 8'hA1; mem[8'h00] = 8'hA2; mem[8'h01] = 8'hA3;
        set_wr(8'h02);
        drain(40);
        check("wrap_rdptr", {24'd0, rd_ptr}, 32'h02);

        // Flush with data unread, one byte in flight and the sink ready.
        ready = 1'b0;
        write_bytes(6);
        repeat (2) tick();
        ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", {31'd0, valid}, 32'd0);
        check("flush_rdptr", {24'd0, rd_ptr}, {24'd0, wr_m});
        check("flush_level", {23'd0, level}, 32'd0);
        check("flush_addr", {24'd0, ram_addr}, {24'd0, 8'(wr_m - 8'd1)});
        repeat (3) tick();
        check("flush_idle_valid", {31'd0, valid}, 32'd0);
        check("flush_idle_addr", {24'd0, ram_addr}, {24'd0, 8'(wr_m - 8'd1)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
